// File: rtl/spi_sram_pkg.sv
// Shared constants and types for the SPI serial-SRAM responder.
package spi_sram_pkg;

  localparam logic [7:0] OP_WRMR  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_RDMR  = 8'h05;

  typedef enum logic [1:0] {
    MODE_BYTE = 2'b00,
    MODE_SEQ  = 2'b01,
    MODE_PAGE = 2'b10
  } mode_e;

  localparam logic [7:0] MODE_RESET = {MODE_SEQ, 6'b0};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_RDATA,
    ST_IGNORE
  } state_e;

endpackage

// File: rtl/spi_sram_responder_if.sv
// SPI pad-side bundle between an initiator and the SRAM responder.
interface spi_sram_responder_if;
  logic sck;
  logic css;
  logic sdi;
  logic sdo;
  logic sdo_oe;

  modport master (output sck, output css, output sdi, input sdo, input sdo_oe);
  modport slave  (input sck, input css, input sdi, output sdo, output sdo_oe);
endinterface

// File: rtl/spi_sync_edge.sv
// 2-flop synchronizer with registered rise/fall strobes (3 clk input-to-strobe).
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic nrst,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);
  logic s1_q, s2_q, s3_q, rise_q, fall_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1_q   <= RST_VAL;
      s2_q   <= RST_VAL;
      s3_q   <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      rise_q <= s2_q & ~s3_q;
      fall_q <= ~s2_q & s3_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
endmodule

// File: rtl/spi_sram_responder.sv
// SPI mode-0 serial-SRAM emulator (READ 0x03 / WRITE 0x02) over an on-chip byte array.
// Define SPI_SRAM_MODEREG_EN to add the WRMR/RDMR mode register (byte/sequential/page).
module spi_sram_responder
  import spi_sram_pkg::*;
#(
  parameter int unsigned MEM_ADDR_W   = 17,
  parameter int unsigned MIN_HALF_CLK = 4
) (
  input  logic                 clk,
  input  logic                 nrst,
  spi_sram_responder_if.slave  spi,
  output logic                 busy,
  output logic                 bad_cmd
);
  localparam int unsigned SH_W = (MEM_ADDR_W > 8) ? MEM_ADDR_W : 8;

  logic sck_rise, sck_fall, css_rise, css_fall;
  logic sdi_s1_q, sdi_s2_q;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sck (
    .clk(clk), .nrst(nrst), .d_i(spi.sck), .rise_o(sck_rise), .fall_o(sck_fall)
  );
  spi_sync_edge #(.RST_VAL(1'b1)) u_css (
    .clk(clk), .nrst(nrst), .d_i(spi.css), .rise_o(css_rise), .fall_o(css_fall)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sdi_s1_q <= 1'b0;
      sdi_s2_q <= 1'b0;
    end else begin
      sdi_s1_q <= spi.sdi;
      sdi_s2_q <= sdi_s1_q;
    end
  end

  state_e                state_q;
  logic [4:0]            bit_q;
  logic [SH_W-2:0]       sh_q;
  logic [SH_W-1:0]       sh_next;
  logic                  wr_q, we_q, load_q, sdo_q, oe_q, bad_q;
  logic [MEM_ADDR_W-1:0] addr_q, waddr_q, addr_inc;
  logic [7:0]            wdata_q, rd_q, out_q, ld_byte;
  logic [7:0]            mem [0:(2**MEM_ADDR_W)-1];
`ifdef SPI_SRAM_MODEREG_EN
  logic                  mr_q;
  logic [7:0]            mode_q;
`endif

  // Upper address bits simply fall off the top of the shifter.
  assign sh_next = {sh_q, sdi_s2_q};

  always_comb begin
`ifdef SPI_SRAM_MODEREG_EN
    ld_byte = mr_q ? mode_q : rd_q;
    case (mode_q[7:6])
      MODE_BYTE: addr_inc = addr_q;
      MODE_PAGE: addr_inc = {addr_q[MEM_ADDR_W-1:5], addr_q[4:0] + 5'd1};
      default:   addr_inc = addr_q + MEM_ADDR_W'(1);
    endcase
`else
    ld_byte  = rd_q;
    addr_inc = addr_q + MEM_ADDR_W'(1);
`endif
  end

  // css edges take priority over sck strobes so a racing css rise commits nothing.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      sh_q    <= '0;
      wr_q    <= 1'b0;
      we_q    <= 1'b0;
      load_q  <= 1'b0;
      sdo_q   <= 1'b0;
      oe_q    <= 1'b0;
      bad_q   <= 1'b0;
      addr_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      out_q   <= '0;
`ifdef SPI_SRAM_MODEREG_EN
      mr_q    <= 1'b0;
      mode_q  <= MODE_RESET;
`endif
    end else begin
      we_q  <= 1'b0;
      bad_q <= 1'b0;
      if (css_rise) begin
        state_q <= ST_IDLE;
        oe_q    <= 1'b0;
        sdo_q   <= 1'b0;
      end else if (css_fall) begin
        state_q <= ST_CMD;
        bit_q   <= '0;
        oe_q    <= 1'b0;
        sdo_q   <= 1'b0;
`ifdef SPI_SRAM_MODEREG_EN
        mr_q    <= 1'b0;
`endif
      end else if (sck_rise) begin
        sh_q  <= sh_next[SH_W-2:0];
        bit_q <= bit_q + 5'd1;
        case (state_q)
          ST_CMD: if (bit_q == 5'd7) begin
            bit_q <= '0;
            case (sh_next[7:0])
              OP_WRITE: begin state_q <= ST_ADDR; wr_q <= 1'b1; end
              OP_READ:  begin state_q <= ST_ADDR; wr_q <= 1'b0; end
`ifdef SPI_SRAM_MODEREG_EN
              OP_WRMR:  begin state_q <= ST_WDATA; mr_q <= 1'b1; end
              OP_RDMR:  begin state_q <= ST_RDATA; mr_q <= 1'b1; load_q <= 1'b1; end
`endif
              default:  begin state_q <= ST_IGNORE; bad_q <= 1'b1; end
            endcase
          end
          ST_ADDR: if (bit_q == 5'd23) begin
            bit_q   <= '0;
            addr_q  <= sh_next[MEM_ADDR_W-1:0];
            load_q  <= 1'b1;
            state_q <= wr_q ? ST_WDATA : ST_RDATA;
          end
          ST_WDATA: if (bit_q == 5'd7) begin
            bit_q <= '0;
`ifdef SPI_SRAM_MODEREG_EN
            if (mr_q) mode_q <= sh_next[7:0];
            else begin
`else
            begin
`endif
              we_q    <= 1'b1;
              waddr_q <= addr_q;
              wdata_q <= sh_next[7:0];
              addr_q  <= addr_inc;
            end
          end
          ST_RDATA: if (bit_q == 5'd7) begin
            bit_q  <= '0;
            load_q <= 1'b1;
`ifdef SPI_SRAM_MODEREG_EN
            if (!mr_q) addr_q <= addr_inc;
`else
            addr_q <= addr_inc;
`endif
          end
          default: ;
        endcase
      end else if (sck_fall && state_q == ST_RDATA) begin
        if (load_q) begin
          sdo_q  <= ld_byte[7];
          out_q  <= {ld_byte[6:0], 1'b0};
          oe_q   <= 1'b1;
          load_q <= 1'b0;
        end else begin
          sdo_q <= out_q[7];
          out_q <= {out_q[6:0], 1'b0};
        end
      end
    end
  end

  // Read port follows addr_q every clk, so the prefetch is ready one clk after any address update.
  always_ff @(posedge clk) begin
    if (we_q) mem[waddr_q] <= wdata_q;
    rd_q <= mem[addr_q];
  end

  assign spi.sdo    = sdo_q;
  assign spi.sdo_oe = oe_q;
  assign busy       = (state_q != ST_IDLE);
  assign bad_cmd    = bad_q;

  logic [7:0] gap_q;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                      gap_q <= '1;
    else if (sck_rise || sck_fall)  gap_q <= '0;
    else if (gap_q != '1)           gap_q <= gap_q + 8'd1;
  end

  a_sck_half_period: assert property (@(posedge clk) disable iff (!nrst)
    (sck_rise || sck_fall) |-> (gap_q >= 8'(MIN_HALF_CLK - 2)));

endmodule

// File: tb/tb_spi_sram_responder.sv
// Directed SPI transactions with a byte scoreboard checked by an sdo monitor.
module tb_spi_sram_responder;
  localparam int H = 6;

  logic clk = 1'b0;
  logic nrst;
  logic busy, bad_cmd;
  always #5 clk = ~clk;

  spi_sram_responder_if spi_if();

  spi_sram_responder #(.MEM_ADDR_W(17), .MIN_HALF_CLK(4)) dut (
    .clk(clk), .nrst(nrst), .spi(spi_if), .busy(busy), .bad_cmd(bad_cmd)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] sb_q[$];
  logic       oe_seen;
  int         bad_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: initiator samples MISO on sck rise while the responder drives it.
  int mbits = 0;
  logic [7:0] mshift = '0;
  always @(posedge spi_if.sck) begin
    if (!spi_if.css && spi_if.sdo_oe) begin
      mshift = {mshift[6:0], spi_if.sdo};
      mbits++;
      if (mbits == 8) begin
        mbits = 0;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_byte: got 0x%0h with no byte expected", mshift);
        end else begin
          check("rd_byte", {24'h0, mshift}, {24'h0, sb_q.pop_front()});
        end
      end
    end
  end
  always @(posedge spi_if.css) mbits = 0;

  always @(negedge clk) if (bad_cmd === 1'b1) bad_cyc++;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    spi_if.sck = 1'b0;
    spi_if.css = 1'b0;
    wait_clk(H);
  endtask

  task automatic cs_high(output int lat);
    wait_clk(H);
    spi_if.css = 1'b1;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (!busy && lat == 0) lat = i;
    end
    wait_clk(H);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_if.sdi = b[i];
      wait_clk(H);
      spi_if.sck = 1'b1;
      if (spi_if.sdo_oe === 1'b1) oe_seen = 1'b1;
      wait_clk(H);
      spi_if.sck = 1'b0;
    end
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [23:0] a);
    send_bits(op, 8);
    send_bits(a[23:16], 8);
    send_bits(a[15:8], 8);
    send_bits(a[7:0], 8);
  endtask

  task automatic write_mem(input logic [23:0] a, input logic [15:0] d, input int nb,
                           input int last_bits, output int lat);
    cs_low();
    send_hdr(8'h02, a);
    if (nb == 1) send_bits(d[15:8], last_bits);
    else begin
      send_bits(d[15:8], 8);
      send_bits(d[7:0], last_bits);
    end
    cs_high(lat);
  endtask

  task automatic read_mem(input logic [23:0] a, input logic [15:0] exp, input int nb);
    int lat;
    sb_q.push_back(exp[15:8]);
    if (nb > 1) sb_q.push_back(exp[7:0]);
    cs_low();
    oe_seen = 1'b0;
    send_hdr(8'h03, a);
    check("hdr_oe", {31'h0, oe_seen}, 0);
    for (int i = 0; i < nb; i++) send_bits(8'h00, 8);
    cs_high(lat);
    check("post_oe", {31'h0, spi_if.sdo_oe}, 0);
    check("sb_pending", sb_q.size(), 0);
  endtask

  task automatic cmd_only(input logic [7:0] op, input logic [7:0] d, input int nb);
    int lat;
    cs_low();
    send_bits(op, 8);
    for (int i = 0; i < nb; i++) send_bits(d, 8);
    cs_high(lat);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int b0;
    spi_if.css = 1'b1;
    spi_if.sck = 1'b0;
    spi_if.sdi = 1'b0;
    nrst = 1'b0;
    wait_clk(3);
    check("rst_sdo",  {31'h0, spi_if.sdo},    0);
    check("rst_oe",   {31'h0, spi_if.sdo_oe}, 0);
    check("rst_busy", {31'h0, busy},          0);
    check("rst_bad",  {31'h0, bad_cmd},       0);
    nrst = 1'b1;
    wait_clk(3);

    // Basic write then read back.
    write_mem(24'h000010, 16'hABCD, 2, 8, lat);
    read_mem(24'h000010, 16'hABCD, 2);

    // Address wrap at top of array.
    write_mem(24'h01FFFF, 16'h1234, 2, 8, lat);
    read_mem(24'h000000, 16'h3400, 1);
    read_mem(24'h01FFFF, 16'h1200, 1);

    // Unsupported opcode held for 40 sck.
    b0 = bad_cyc;
    cs_low();
    oe_seen = 1'b0;
    send_bits(8'h9F, 8);
    for (int i = 0; i < 4; i++) send_bits(8'h00, 8);
    check("ignore_busy", {31'h0, busy}, 1);
    cs_high(lat);
    check("bad_pulse_cycles", bad_cyc - b0, 1);
    check("ignore_oe", {31'h0, oe_seen}, 0);
    read_mem(24'h000010, 16'hAB00, 1);

    // Aborted write leaves prior contents.
    write_mem(24'h000020, 16'h5A00, 1, 8, lat);
    write_mem(24'h000020, 16'hFF00, 1, 5, lat);
    check($sformatf("busy_fall_lat=%0d", lat), {31'h0, (lat >= 3 && lat <= 4)}, 1);
    read_mem(24'h000020, 16'h5A00, 1);

    // Reset in the middle of read data.
    cs_low();
    send_hdr(8'h03, 24'h000010);
    send_bits(8'h00, 3);
    nrst = 1'b0;
    #1;
    check("midrst_sdo",  {31'h0, spi_if.sdo},    0);
    check("midrst_oe",   {31'h0, spi_if.sdo_oe}, 0);
    check("midrst_busy", {31'h0, busy},          0);
    spi_if.sck = 1'b0;
    spi_if.css = 1'b1;
    wait_clk(3);
    nrst = 1'b1;
    wait_clk(3);
    read_mem(24'h000010, 16'hABCD, 2);

`ifdef SPI_SRAM_MODEREG_EN
    cmd_only(8'h01, 8'h00, 1);
    read_mem(24'h000010, 16'hABAB, 2);
    sb_q.push_back(8'h00);
    cmd_only(8'h05, 8'h00, 1);
    check("rdmr_pending", sb_q.size(), 0);
    nrst = 1'b0;
    wait_clk(3);
    nrst = 1'b1;
    wait_clk(3);
    sb_q.push_back(8'h40);
    sb_q.push_back(8'h40);
    cmd_only(8'h05, 8'h00, 2);
    check("rdmr_rst_pending", sb_q.size(), 0);
`else
    b0 = bad_cyc;
    cmd_only(8'h01, 8'h00, 1);
    check("wrmr_unsupported", bad_cyc - b0, 1);
    b0 = bad_cyc;
    cmd_only(8'h05, 8'h00, 1);
    check("rdmr_unsupported", bad_cyc - b0, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
